dcim_arbiter: RTL and testbench

DCIM_ARBITER -- requirements
Module: dcim_arbiter

---
 rtl/dcim_arb_pkg.sv | 22 ++
 rtl/dcim_arbiter_rr_arb2.sv | 20 ++
 rtl/dcim_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_dcim_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dcim_arb_pkg.sv
// Shared definitions for the digital compute-in-memory arbiter.
// State encoding, default widths and weight-load counter constants.
package dcim_arb_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_PROD_WIDTH = 16;

    // Weight-load counter: 5 bits wide, wraps back to RUN on the 16th write.
    localparam int             WCNT_W    = 5;
    localparam logic [WCNT_W-1:0] WCNT_LAST = 5'd15;

    // Width of the optional per-requester grant counters.
    localparam int PERF_W = 16;

endpackage

// File: rtl/dcim_arbiter_rr_arb2.sv
// Two-way round-robin selector. ptr names the requester that wins
// when both are requesting; a lone requester always wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    // One-hot grant from the request vector and the priority pointer.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dcim_arbiter.sv
// Arbiter in front of a single-port weight SRAM and a combinational
// multiplier. A weight-load port fills 16 rows (LOAD), after which two
// compute requesters share the SRAM round-robin (RUN), with writes taking
// precedence. reload drains the 2-stage response pipeline (DRAIN) and
// returns to LOAD.
// Optional feature: define DCIM_ARB_PERF_EN to add saturating per-requester
// compute grant counters perf_gnt0 / perf_gnt1.
module dcim_arbiter
    import dcim_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int PROD_WIDTH = DEF_PROD_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // weight-load port
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    // compute requesters, slice i belongs to requester i
    input  logic [1:0]              rq_valid,
    output logic [1:0]              rq_ready,
    input  logic [2*ADDR_WIDTH-1:0] rq_addr,
    input  logic [2*DATA_WIDTH-1:0] rq_act,
    input  logic                    reload,
    // SRAM
    output logic                    sram_ce,
    output logic                    sram_we,
    output logic [ADDR_WIDTH-1:0]   sram_addr,
    output logic [DATA_WIDTH-1:0]   sram_wdata,
    input  logic [DATA_WIDTH-1:0]   sram_rdata,
    // multiplier
    output logic [DATA_WIDTH-1:0]   mul_a,
    output logic [DATA_WIDTH-1:0]   mul_b,
    input  logic [PROD_WIDTH-1:0]   mul_p,
    // response
    output logic                    rsp_valid,
    output logic                    rsp_id,
    output logic [PROD_WIDTH-1:0]   rsp_data,
`ifdef DCIM_ARB_PERF_EN
    output logic [PERF_W-1:0]       perf_gnt0,
    output logic [PERF_W-1:0]       perf_gnt1,
`endif
    output logic                    init_done,
    output logic                    busy
);

    state_t            state, state_nxt;
    logic [WCNT_W-1:0] wcnt, wcnt_nxt;
    logic              rr_ptr, rr_ptr_nxt;
    logic [1:0]        rr_gnt;

    logic                  wr_acc;
    logic                  cmp_acc;
    logic                  cmp_id;
    logic [DATA_WIDTH-1:0] cmp_act;

    logic                  vld_p0, vld_p1;
    logic                  id_p0, id_p1;
    logic [DATA_WIDTH-1:0] act_p0;
    logic [PROD_WIDTH-1:0] prod_p1;

    rr_arb2 u_rr_arb2 (
        .req (rq_valid),
        .ptr (rr_ptr),
        .gnt (rr_gnt)
    );

    // Grant decision: writes first, compute only in RUN with no reload pending.
    always_comb begin
        wr_ready = (state == LOAD) || (state == RUN);
        wr_acc   = wr_valid && wr_ready;
        rq_ready = 2'b00;
        if ((state == RUN) && !wr_valid && !reload) begin
            rq_ready = rr_gnt;
        end
        cmp_acc = |rq_ready;
        cmp_id  = rq_ready[1];
        cmp_act = cmp_id ? rq_act[2*DATA_WIDTH-1:DATA_WIDTH] : rq_act[DATA_WIDTH-1:0];
    end

    // SRAM command for the single granted access of this cycle.
    always_comb begin
        sram_ce    = wr_acc || cmp_acc;
        sram_we    = wr_acc;
        sram_addr  = '0;
        sram_wdata = '0;
        if (wr_acc) begin
            sram_addr  = wr_addr;
            sram_wdata = wr_data;
        end else if (cmp_acc) begin
            sram_addr = cmp_id ? rq_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                               : rq_addr[ADDR_WIDTH-1:0];
        end
    end

    // Next-state, weight counter and round-robin pointer.
    always_comb begin
        state_nxt  = state;
        wcnt_nxt   = wcnt;
        rr_ptr_nxt = cmp_acc ? ~cmp_id : rr_ptr;
        case (state)
            LOAD: begin
                if (wr_acc) begin
                    if (wcnt == WCNT_LAST) begin
                        state_nxt = RUN;
                        wcnt_nxt  = '0;
                    end else begin
                        wcnt_nxt = wcnt + 1'b1;
                    end
                end
            end
            RUN: begin
                if (reload) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!vld_p0 && !vld_p1) begin
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    // Control state registers, including pipeline valids.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= LOAD;
            wcnt   <= '0;
            rr_ptr <= 1'b0;
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            state  <= state_nxt;
            wcnt   <= wcnt_nxt;
            rr_ptr <= rr_ptr_nxt;
            vld_p0 <= cmp_acc;
            vld_p1 <= vld_p0;
        end
    end

    // Stage p0: capture activation and requester id at the accept cycle.
    always_ff @(posedge clk) begin
        if (cmp_acc) begin
            act_p0 <= cmp_act;
            id_p0  <= cmp_id;
        end
    end

    // Stage p1: capture the product of the weight read back and the activation.
    always_ff @(posedge clk) begin
        if (vld_p0) begin
            prod_p1 <= mul_p;
            id_p1   <= id_p0;
        end
    end

    // Multiplier operands are quiet unless stage p0 holds an entry.
    always_comb begin
        mul_a = vld_p0 ? act_p0     : '0;
        mul_b = vld_p0 ? sram_rdata : '0;
    end

    // Response and status outputs; data is forced to zero without a valid.
    always_comb begin
        rsp_valid = vld_p1;
        rsp_id    = vld_p1 && id_p1;
        rsp_data  = vld_p1 ? prod_p1 : '0;
        init_done = (state == RUN);
        busy      = vld_p0 || vld_p1;
    end

`ifdef DCIM_ARB_PERF_EN
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (v == {PERF_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Saturating grant counters, cleared by reset and on entry to LOAD.
    always_ff @(posedge clk) begin
        if (!rst_n || ((state != LOAD) && (state_nxt == LOAD))) begin
            perf_gnt0 <= '0;
            perf_gnt1 <= '0;
        end else begin
            if (rq_ready[0]) perf_gnt0 <= sat_inc(perf_gnt0);
            if (rq_ready[1]) perf_gnt1 <= sat_inc(perf_gnt1);
        end
    end
`endif

endmodule

// File: tb/tb_dcim_arbiter.sv
// Directed bench for dcim_arbiter with a behavioural SRAM and multiplier.
module tb_dcim_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [1:0]  rq_valid;
    logic [1:0]  rq_ready;
    logic [7:0]  rq_addr;
    logic [15:0] rq_act;
    logic        reload;
    logic        sram_ce, sram_we;
    logic [3:0]  sram_addr;
    logic [7:0]  sram_wdata;
    logic [7:0]  sram_rdata = 8'd0;
    logic [7:0]  mul_a, mul_b;
    logic [15:0] mul_p;
    logic        rsp_valid, rsp_id;
    logic [15:0] rsp_data;
    logic        init_done, busy;
`ifdef DCIM_ARB_PERF_EN
    logic [15:0] perf_gnt0, perf_gnt1;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem [16];

    always #5 clk = ~clk;

    // Single-port synchronous SRAM, read data one cycle after the read.
    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_we) mem[sram_addr] <= sram_wdata;
            else         sram_rdata     <= mem[sram_addr];
        end
    end

    assign mul_p = mul_a * mul_b;

    dcim_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rq_valid   (rq_valid),
        .rq_ready   (rq_ready),
        .rq_addr    (rq_addr),
        .rq_act     (rq_act),
        .reload     (reload),
        .sram_ce    (sram_ce),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_p      (mul_p),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
`ifdef DCIM_ARB_PERF_EN
        .perf_gnt0  (perf_gnt0),
        .perf_gnt1  (perf_gnt1),
`endif
        .init_done  (init_done),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic load_all(input logic [1:0] rqv);
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1;
            wr_addr  = 4'(i);
            wr_data  = 8'(i + 1);
            rq_valid = rqv;
            #1;
            chk("load_rq_ready", 32'(rq_ready), 32'd0);
            chk("load_sram_we", 32'(sram_we), 32'd1);
            if (i == 15) chk("load_init_done_before_last", 32'(init_done), 32'd0);
            next();
        end
        wr_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        rq_valid = '0; rq_addr = '0; rq_act = '0; reload = 1'b0;
        next();
        next();
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_sram_ce", 32'(sram_ce), 32'd0);
        rst_n = 1'b1;

        // Load rows with i+1 while both requesters knock.
        rq_addr = 8'h33;
        rq_act  = 16'h0A0A;
        load_all(2'b11);

        // Alternating grants, responses of 4*10 two cycles after each accept.
        for (int k = 0; k < 6; k++) begin
            rq_valid = 2'b11;
            #1;
            if (k == 0) chk("run_init_done", 32'(init_done), 32'd1);
            chk("rr_grant", 32'(rq_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
            chk("rr_sram_addr", 32'(sram_addr), 32'd3);
            if (k == 1) begin
                chk("mul_a", 32'(mul_a), 32'd10);
                chk("mul_b", 32'(mul_b), 32'd4);
            end
            if (k < 2) begin
                chk("rr_rsp_idle", 32'(rsp_valid), 32'd0);
            end else begin
                chk("rr_rsp_valid", 32'(rsp_valid), 32'd1);
                chk("rr_rsp_id", 32'(rsp_id), 32'(k % 2));
                chk("rr_rsp_data", 32'(rsp_data), 32'd40);
            end
            next();
        end
        rq_valid = 2'b00;
        #1;
        chk("tail0_valid", 32'(rsp_valid), 32'd1);
        chk("tail0_id", 32'(rsp_id), 32'd0);
        next();
        chk("tail1_id", 32'(rsp_id), 32'd1);
        chk("tail1_busy", 32'(busy), 32'd1);
        next();
        chk("tail_idle_valid", 32'(rsp_valid), 32'd0);
        chk("tail_idle_data", 32'(rsp_data), 32'd0);
        chk("tail_idle_busy", 32'(busy), 32'd0);

        // Write and compute in the same cycle: write wins, rq0 next cycle.
        wr_valid = 1'b1; wr_addr = 4'd7; wr_data = 8'd9;
        rq_valid = 2'b01; rq_addr = 8'h07; rq_act = 16'h0003;
        #1;
        chk("prio_we", 32'(sram_we), 32'd1);
        chk("prio_rq_blocked", 32'(rq_ready), 32'd0);
        chk("prio_addr", 32'(sram_addr), 32'd7);
        next();
        wr_valid = 1'b0;
        #1;
        chk("prio_rq_next", 32'(rq_ready), 32'd1);
        chk("prio_we_off", 32'(sram_we), 32'd0);
        next();
        rq_valid = 2'b00;
        #1;
        chk("prio_rsp_early", 32'(rsp_valid), 32'd0);
        next();
        chk("prio_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("prio_rsp_data", 32'(rsp_data), 32'd27);

        // Write row 5 = 200, read it next cycle with act 255 on requester 1.
        wr_valid = 1'b1; wr_addr = 4'd5; wr_data = 8'd200;
        #1;
        next();
        wr_valid = 1'b0; rq_valid = 2'b10; rq_addr = 8'h50; rq_act = 16'hFF00;
        #1;
        chk("fwd_grant", 32'(rq_ready), 32'd2);
        next();
        rq_valid = 2'b00;
        #1;
        next();
        chk("fwd_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("fwd_rsp_id", 32'(rsp_id), 32'd1);
        chk("fwd_rsp_data", 32'(rsp_data), 32'd51000);

        // Reload with two responses in flight.
        rq_valid = 2'b11; rq_addr = 8'h33; rq_act = 16'h0A0A;
        #1;
        chk("rl_g0", 32'(rq_ready), 32'd1);
        next();
        chk("rl_g1", 32'(rq_ready), 32'd2);
        next();
        reload = 1'b1;
        #1;
        chk("rl_blocked", 32'(rq_ready), 32'd0);
        chk("rl_no_ce", 32'(sram_ce), 32'd0);
        chk("rl_rsp0_valid", 32'(rsp_valid), 32'd1);
        chk("rl_rsp0_id", 32'(rsp_id), 32'd0);
        chk("rl_rsp0_data", 32'(rsp_data), 32'd40);
        next();
        reload = 1'b0;
        #1;
        chk("drain_init_done", 32'(init_done), 32'd0);
        chk("drain_rq_ready", 32'(rq_ready), 32'd0);
        chk("drain_rsp1_valid", 32'(rsp_valid), 32'd1);
        chk("drain_rsp1_id", 32'(rsp_id), 32'd1);
        chk("drain_rsp1_data", 32'(rsp_data), 32'd40);
        next();
        chk("drain_empty_busy", 32'(busy), 32'd0);
        chk("drain_empty_rsp", 32'(rsp_valid), 32'd0);
        chk("drain_wr_ready", 32'(wr_ready), 32'd0);
        next();
        rq_valid = 2'b00; reload = 1'b1;
        #1;
        chk("load_again_wr_ready", 32'(wr_ready), 32'd1);
        chk("load_again_init_done", 32'(init_done), 32'd0);
        next();
        reload = 1'b0;
        load_all(2'b00);

        // Reset with a full pipeline drops both in-flight responses.
        rq_valid = 2'b11; rq_addr = 8'h33; rq_act = 16'h0A0A;
        #1;
        chk("reload_run_init_done", 32'(init_done), 32'd1);
        next();
        next();
        rst_n = 1'b0; rq_valid = 2'b00;
        #1;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        next();
        rst_n = 1'b1;
        #1;
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("mid_rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_init_done", 32'(init_done), 32'd0);
        chk("mid_rst_sram_ce", 32'(sram_ce), 32'd0);
        chk("mid_rst_mul_a", 32'(mul_a), 32'd0);
        chk("mid_rst_mul_b", 32'(mul_b), 32'd0);
        next();
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
